// File: rtl/adder_bist.sv
// ---------------------------------------------------------------------------
// adder_bist
//
// Built-in self-test engine for an N-bit adder under test. The engine drives
// four fixed corner vectors followed by pseudo-random vectors from a 32-bit
// Galois LFSR. It computes the expected sum and carry-out internally and
// compares them with the adder's response. It counts the vectors compared and
// the mismatches, and it captures the operands of the first failing vector.
//
// Parameters:
//   N            operand width (4..64)
//   NUM_VECTORS  vectors per run (>= 5)
//   DUV_LAT      latency of the adder under test in cycles (0..4)
//   SEED         LFSR seed (nonzero)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin a run (accepted only in IDLE or DONE)
//   a_o, b_o, cin_o     operands driven to the adder under test
//   s_i, cout_i         sum and carry-out returned by the adder under test
//   prop_i, gen_i       group propagate/generate returned by the adder
//   busy, done, pass    run status; pass is valid while done is high
//   vec_count           number of vectors compared
//   err_count           number of mismatching vectors (saturating)
//   fail_valid          a first failure has been captured
//   fail_a/b/cin        operands of the first failing vector
//
// Configuration macro:
//   ADDER_BIST_PG_CHECK_EN  when defined, prop_i/gen_i mismatches also count
//                           as failures; otherwise both inputs are ignored.
// ---------------------------------------------------------------------------
module adder_bist #(
    parameter int          N           = 16,
    parameter int unsigned NUM_VECTORS = 30000,
    parameter int          DUV_LAT     = 0,
    parameter logic [31:0] SEED        = 32'h1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [N-1:0]  a_o,
    output logic [N-1:0]  b_o,
    output logic          cin_o,
    input  logic [N-1:0]  s_i,
    input  logic          cout_i,
    input  logic          prop_i,
    input  logic          gen_i,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [31:0]   vec_count,
    output logic [31:0]   err_count,
    output logic          fail_valid,
    output logic [N-1:0]  fail_a,
    output logic [N-1:0]  fail_b,
    output logic          fail_cin
);

    // Stage 0 of the delay line is the operand output register itself, so the
    // stage that is compared sits DUV_LAT stages further down.
    localparam int          DEPTH     = DUV_LAT + 1;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] LAST_IDX  = NUM_VECTORS - 1;
    localparam logic [63:0] ALT01     = {32{2'b01}};
    localparam logic [63:0] ALT10     = {32{2'b10}};
    localparam logic [N-1:0] ALT_A    = ALT01[N-1:0];
    localparam logic [N-1:0] ALT_B    = ALT10[N-1:0];

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [N-1:0] pipe_a     [DEPTH];
    logic [N-1:0] pipe_b     [DEPTH];
    logic         pipe_cin   [DEPTH];
    logic         pipe_valid [DEPTH];
    logic         pipe_last  [DEPTH];

    logic [31:0]  vec_idx;
    logic [31:0]  lfsr;
    logic [31:0]  lfsr_next;
    logic [31:0]  lfsr_rot;
    logic [63:0]  lfsr_rep;
    logic [63:0]  rot_rep;

    logic         start_run;
    logic         issue;
    logic         issue_last;
    logic         finish;
    logic [31:0]  sel_idx;

    logic [N-1:0] vec_a;
    logic [N-1:0] vec_b;
    logic         vec_cin;

    logic [N-1:0] cmp_a;
    logic [N-1:0] cmp_b;
    logic         cmp_cin;
    logic         cmp_valid;
    logic         cmp_last;
    logic [N:0]   exp_sum;
    logic         mismatch;

    // Vector 0 is issued on the start edge itself; later vectors come from the
    // running index while the FSM stays in RUN.
    assign sel_idx = start_run ? 32'd0 : vec_idx;

    assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'd0);
    assign lfsr_rot  = {lfsr[15:0], lfsr[31:16]};
    assign lfsr_rep  = {lfsr, lfsr};
    assign rot_rep   = {lfsr_rot, lfsr_rot};

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the control strobes used by the datapath
    always_comb begin
        state_next = state;
        start_run  = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_run  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (vec_idx == LAST_IDX) begin
                    issue_last = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (cmp_valid && cmp_last) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Vector source: four corners, then the LFSR state (current state is
    // used, then the LFSR steps, so the first random vector uses SEED).
    always_comb begin
        vec_a   = '0;
        vec_b   = '0;
        vec_cin = 1'b0;
        case (sel_idx)
            32'd0: begin
                vec_a   = '0;
                vec_b   = '0;
                vec_cin = 1'b0;
            end
            32'd1: begin
                vec_a   = '1;
                vec_b   = {{(N-1){1'b0}}, 1'b1};
                vec_cin = 1'b0;
            end
            32'd2: begin
                vec_a   = '1;
                vec_b   = '1;
                vec_cin = 1'b1;
            end
            32'd3: begin
                vec_a   = ALT_A;
                vec_b   = ALT_B;
                vec_cin = 1'b1;
            end
            default: begin
                vec_a   = lfsr_rep[N-1:0];
                vec_b   = rot_rep[N-1:0];
                vec_cin = lfsr[31] ^ lfsr[0];
            end
        endcase
    end

    // Reference result for the vector at the end of the delay line
    always_comb begin
        cmp_a     = pipe_a[DUV_LAT];
        cmp_b     = pipe_b[DUV_LAT];
        cmp_cin   = pipe_cin[DUV_LAT];
        cmp_valid = pipe_valid[DUV_LAT];
        cmp_last  = pipe_last[DUV_LAT];
        exp_sum   = {1'b0, cmp_a} + {1'b0, cmp_b} + {{N{1'b0}}, cmp_cin};
    end

`ifdef ADDER_BIST_PG_CHECK_EN
    logic [N:0] exp_ab;
    logic       exp_prop;
    logic       exp_gen;

    // Group propagate/generate are checked in addition to sum and carry-out;
    // generate is the carry-out with the carry-in forced to zero.
    always_comb begin
        exp_ab   = {1'b0, cmp_a} + {1'b0, cmp_b};
        exp_prop = &(cmp_a ^ cmp_b);
        exp_gen  = exp_ab[N];
        mismatch = (s_i != exp_sum[N-1:0]) || (cout_i != exp_sum[N]) ||
                   (prop_i != exp_prop) || (gen_i != exp_gen);
    end
`else
    logic unused_pg;

    // Propagate/generate are not part of the check in this build.
    assign unused_pg = prop_i ^ gen_i;

    always_comb begin
        mismatch = (s_i != exp_sum[N-1:0]) || (cout_i != exp_sum[N]);
    end
`endif

    // Operand delay line, counters, status flags and first-failure capture
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_a[i]     <= '0;
                pipe_b[i]     <= '0;
                pipe_cin[i]   <= 1'b0;
                pipe_valid[i] <= 1'b0;
                pipe_last[i]  <= 1'b0;
            end
            vec_idx    <= '0;
            lfsr       <= SEED;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            vec_count  <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_cin   <= 1'b0;
        end else if (start_run) begin
            pipe_a[0]     <= vec_a;
            pipe_b[0]     <= vec_b;
            pipe_cin[0]   <= vec_cin;
            pipe_valid[0] <= 1'b1;
            pipe_last[0]  <= 1'b0;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_a[i]     <= '0;
                pipe_b[i]     <= '0;
                pipe_cin[i]   <= 1'b0;
                pipe_valid[i] <= 1'b0;
                pipe_last[i]  <= 1'b0;
            end
            vec_idx    <= 32'd1;
            lfsr       <= SEED;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            vec_count  <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_cin   <= 1'b0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                pipe_a[i]     <= pipe_a[i-1];
                pipe_b[i]     <= pipe_b[i-1];
                pipe_cin[i]   <= pipe_cin[i-1];
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_last[i]  <= pipe_last[i-1];
            end

            // Stage 0 doubles as the operand outputs: a new vector in RUN,
            // the last vector held (but not re-compared) in DRAIN, zero once
            // the run has finished.
            if (issue) begin
                pipe_a[0]     <= vec_a;
                pipe_b[0]     <= vec_b;
                pipe_cin[0]   <= vec_cin;
                pipe_valid[0] <= 1'b1;
                pipe_last[0]  <= issue_last;
                vec_idx       <= vec_idx + 32'd1;
                if (vec_idx >= 32'd4) begin
                    lfsr <= lfsr_next;
                end
            end else if (finish) begin
                pipe_a[0]     <= '0;
                pipe_b[0]     <= '0;
                pipe_cin[0]   <= 1'b0;
                pipe_valid[0] <= 1'b0;
                pipe_last[0]  <= 1'b0;
            end else begin
                pipe_valid[0] <= 1'b0;
                pipe_last[0]  <= 1'b0;
            end

            if (cmp_valid) begin
                vec_count <= vec_count + 32'd1;
                if (mismatch) begin
                    if (err_count != 32'hFFFF_FFFF) begin
                        err_count <= err_count + 32'd1;
                    end
                    if (!fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_a     <= cmp_a;
                        fail_b     <= cmp_b;
                        fail_cin   <= cmp_cin;
                    end
                end
            end

            // The final compare lands on this same edge, so its own result
            // is folded into pass.
            if (finish) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (err_count == 32'd0) && !mismatch;
            end
        end
    end

    assign a_o   = pipe_a[0];
    assign b_o   = pipe_b[0];
    assign cin_o = pipe_cin[0];

endmodule
